// File: rtl/icache_ctrl.sv
// icache_ctrl: tag/valid/LRU owner and fetch sequencer for a 2-way
// set-associative instruction cache. Looks up each fetch, refills a whole
// line from instruction memory on a miss, and steers the external data array.
module icache_ctrl #(
    parameter int WORD_SIZE    = 32,
    parameter int BLOCK_SIZE   = 16,
    parameter int SET_SIZE     = 1024,
    parameter int CHANNEL_SIZE = 2,
    parameter int TAG_SIZE     = 18,
    parameter int CNT_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inst_get,
    input  logic [WORD_SIZE-1:0]        ptr,
    input  logic                        flush,
    output logic                        ready,
    output logic                        hit,
    output logic                        busy,
    output logic                        mem_req,
    output logic [WORD_SIZE-1:0]        mem_addr,
    input  logic                        mem_ack,
    input  logic [WORD_SIZE-1:0]        mem_rdata,
    output logic                        da_we,
    output logic                        da_way,
    output logic [$clog2(SET_SIZE)-1:0] da_set,
    output logic [$clog2(BLOCK_SIZE)-1:0] da_off,
    output logic [WORD_SIZE-1:0]        da_wdata,
    output logic [CNT_W-1:0]            hit_cnt,
    output logic [CNT_W-1:0]            miss_cnt
);
    localparam int OFF_W = $clog2(BLOCK_SIZE);
    localparam int IDX_W = $clog2(SET_SIZE);

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] req_q, req_d;
    logic                 way_q, way_d;
    logic                 hflag_q, hflag_d;
    logic [OFF_W-1:0]     cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 hit_q, hit_d;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;

    logic [CHANNEL_SIZE-1:0][SET_SIZE-1:0] valid_q;
    logic [SET_SIZE-1:0]                   lru_q;
    logic [TAG_SIZE-1:0]                   tag_q [CHANNEL_SIZE][SET_SIZE];

    logic [TAG_SIZE-1:0] req_tag;
    logic [IDX_W-1:0]    req_set;
    logic [OFF_W-1:0]    req_off;
    logic                hit0, hit1, victim;
    logic                valid_clr, fill_we, lru_we, lru_val;

    assign req_tag = req_q[WORD_SIZE-1 -: TAG_SIZE];
    assign req_set = req_q[OFF_W +: IDX_W];
    assign req_off = req_q[OFF_W-1:0];

    assign hit0 = valid_q[0][req_set] && (tag_q[0][req_set] == req_tag);
    assign hit1 = valid_q[1][req_set] && (tag_q[1][req_set] == req_tag);
    // First invalid way wins (way 0 first), otherwise the LRU way.
    assign victim = !valid_q[0][req_set] ? 1'b0 :
                    !valid_q[1][req_set] ? 1'b1 : lru_q[req_set];

    // Next-state and control decode for the fetch sequencer.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        way_d      = way_q;
        hflag_d    = hflag_q;
        cnt_d      = cnt_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        ready_d    = 1'b0;
        hit_d      = 1'b0;
        valid_clr  = 1'b0;
        fill_we    = 1'b0;
        lru_we     = 1'b0;
        lru_val    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_clr = 1'b1;
                end else if (inst_get) begin
                    req_d   = ptr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit0 || hit1) begin
                    // Way 0 takes precedence should both ever match.
                    way_d     = hit0 ? 1'b0 : 1'b1;
                    hflag_d   = 1'b1;
                    lru_we    = 1'b1;
                    lru_val   = hit0 ? 1'b1 : 1'b0;
                    hit_cnt_d = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;
                    state_d   = RESP;
                end else begin
                    way_d      = victim;
                    hflag_d    = 1'b0;
                    cnt_d      = '0;
                    miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(BLOCK_SIZE - 1)) begin
                        fill_we = 1'b1;
                        lru_we  = 1'b1;
                        lru_val = ~way_q;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                ready_d = 1'b1;
                hit_d   = hflag_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, latched request and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            way_q      <= 1'b0;
            hflag_q    <= 1'b0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            hit_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            way_q      <= way_d;
            hflag_q    <= hflag_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            hit_q      <= hit_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Valid and LRU bits; flush clears every line at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            if (valid_clr)
                valid_q <= '0;
            else if (fill_we)
                valid_q[way_q][req_set] <= 1'b1;
            if (lru_we)
                lru_q[req_set] <= lru_val;
        end
    end

    // Tag array; written only when a refill completes, never under reset.
    always_ff @(posedge clk) begin
        if (fill_we && !rst)
            tag_q[way_q][req_set] <= req_tag;
    end

    assign ready    = ready_q;
    assign hit      = hit_q;
    assign busy     = (state_q != IDLE);
    assign mem_req  = (state_q == REFILL);
    assign mem_addr = {req_tag, req_set, cnt_q};
    assign da_we    = mem_req && mem_ack;
    assign da_way   = way_q;
    assign da_set   = req_set;
    assign da_off   = (state_q == REFILL) ? cnt_q : req_off;
    assign da_wdata = mem_rdata;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed fetch sequences with a scoreboard. The stimulus
// thread pushes the expected response; a monitor thread checks every data
// array write and pops/compares on each ready pulse.
module tb_icache_ctrl;
    logic        clk = 1'b0;
    logic        rst, inst_get, flush, mem_ack;
    logic [31:0] ptr;
    logic        ready, hit, busy, mem_req, da_we, da_way;
    logic [31:0] mem_addr, mem_rdata, da_wdata;
    logic [9:0]  da_set;
    logic [3:0]  da_off;
    logic [15:0] hit_cnt, miss_cnt;

    typedef struct {
        logic [31:0] p;
        logic        h;
        logic        w;
        int          lat;
        int          nwr;
        int          t0;
    } exp_t;

    exp_t        q[$];
    logic [31:0] da_model [2][1024][16];
    int          cyc, wcnt, nresp, tests, fails;
    logic        stall, req_seen;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h0101_0003) ^ 32'hC0DE_0000;
    endfunction

    assign mem_rdata = memf(mem_addr);

    icache_ctrl dut (
        .clk(clk), .rst(rst), .inst_get(inst_get), .ptr(ptr), .flush(flush),
        .ready(ready), .hit(hit), .busy(busy), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .da_we(da_we), .da_way(da_way), .da_set(da_set), .da_off(da_off),
        .da_wdata(da_wdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Issue one fetch; hold=1 raises flush alongside it for the first cycle.
    task automatic req(input logic [31:0] p, input logic h, input logic w,
                       input int lat, input logic hold);
        exp_t e;
        int   n0;
        bit   done;
        @(posedge clk); #1;
        e.p = p; e.h = h; e.w = w; e.lat = lat; e.nwr = h ? 0 : 16;
        e.t0 = cyc + (hold ? 1 : 0);
        q.push_back(e);
        n0 = nresp;
        ptr = p; inst_get = 1'b1; flush = hold;
        if (hold) begin
            @(posedge clk); #1;
            flush = 1'b0;
        end
        @(posedge clk); #1;
        inst_get = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (nresp != n0) done = 1'b1;
        end
        if (!done) chk("resp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst = 1'b1; inst_get = 1'b0; flush = 1'b0; ptr = '0; stall = 1'b0;
        tests = 0; fails = 0; cyc = 0; wcnt = 0; nresp = 0; req_seen = 1'b0;
        mem_ack = 1'b1;
        fork
            forever begin
                @(posedge clk);
                cyc++;
                #1 mem_ack = stall ? (cyc % 3 == 0) : 1'b1;
            end
            // Monitor: write-path checks every cycle, response check on ready.
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst) begin
                    q.delete();
                    wcnt = 0;
                    req_seen = 1'b0;
                end else begin
                    if (mem_req) req_seen = 1'b1;
                    if (da_we) begin
                        chk("we_in_refill", {63'd0, mem_req}, 64'd1);
                        chk("wr_off_seq", {60'd0, da_off}, wcnt[3:0]);
                        chk("wr_addr_off", {60'd0, mem_addr[3:0]}, {60'd0, da_off});
                        chk("wr_addr_set", {54'd0, mem_addr[13:4]}, {54'd0, da_set});
                        chk("wr_data", {32'd0, da_wdata}, {32'd0, memf(mem_addr)});
                        da_model[da_way][da_set][da_off] = da_wdata;
                        wcnt++;
                    end
                    if (ready) begin
                        if (q.size() == 0) begin
                            chk("unexpected_ready", 64'd1, 64'd0);
                        end else begin
                            e = q.pop_front();
                            chk("hit", {63'd0, hit}, {63'd0, e.h});
                            chk("way", {63'd0, da_way}, {63'd0, e.w});
                            chk("set", {54'd0, da_set}, {54'd0, e.p[13:4]});
                            chk("off", {60'd0, da_off}, {60'd0, e.p[3:0]});
                            chk("rd_data", {32'd0, da_model[da_way][da_set][da_off]},
                                {32'd0, memf(e.p)});
                            chk("nwrites", wcnt, e.nwr);
                            chk("mem_req_seen", {63'd0, req_seen}, {63'd0, e.nwr != 0});
                            if (e.lat != 0) chk("latency", cyc - e.t0, e.lat);
                        end
                        wcnt = 0;
                        req_seen = 1'b0;
                        nresp++;
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_da_we", {63'd0, da_we}, 64'd0);
        chk("rst_hit_cnt", {48'd0, hit_cnt}, 64'd0);
        chk("rst_miss_cnt", {48'd0, miss_cnt}, 64'd0);

        // Cold miss then hit in the same line.
        req(32'h0000_0040, 1'b0, 1'b0, 19, 1'b0);
        chk("miss_cnt_1", {48'd0, miss_cnt}, 64'd1);
        req(32'h0000_0045, 1'b1, 1'b0, 3, 1'b0);
        chk("hit_cnt_1", {48'd0, hit_cnt}, 64'd1);

        // LRU: A=tag0 way0, B=tag1 way1, touch A, C replaces B, A hits, B replaces C.
        req(32'h0000_4040, 1'b0, 1'b1, 19, 1'b0);
        req(32'h0000_0041, 1'b1, 1'b0, 3, 1'b0);
        req(32'h0000_8042, 1'b0, 1'b1, 19, 1'b0);
        req(32'h0000_0047, 1'b1, 1'b0, 3, 1'b0);
        req(32'h0000_4043, 1'b0, 1'b1, 19, 1'b0);

        // Stalled memory: ack only every third cycle.
        stall = 1'b1;
        req(32'h1234_5678, 1'b0, 1'b0, 0, 1'b0);
        stall = 1'b0;

        // Flush together with inst_get: flush first, held request then misses.
        req(32'h0000_0040, 1'b0, 1'b0, 19, 1'b1);
        chk("hit_cnt_6", {48'd0, hit_cnt}, 64'd3);
        chk("miss_cnt_6", {48'd0, miss_cnt}, 64'd6);

        // Reset in the middle of a refill.
        @(posedge clk); #1;
        begin
            exp_t e;
            e.p = 32'h0000_0200; e.h = 1'b0; e.w = 1'b0; e.lat = 0; e.nwr = 16; e.t0 = cyc;
            q.push_back(e);
        end
        ptr = 32'h0000_0200; inst_get = 1'b1;
        @(posedge clk); #1;
        inst_get = 1'b0;
        begin
            bit got7 = 1'b0;
            for (int i = 0; i < 100 && !got7; i++) begin
                @(negedge clk);
                if (wcnt >= 7) got7 = 1'b1;
            end
            if (!got7) chk("refill_progress", 64'd0, 64'd1);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_miss_cnt", {48'd0, miss_cnt}, 64'd0);
        req(32'h0000_0200, 1'b0, 1'b0, 19, 1'b0);
        req(32'h0000_0205, 1'b1, 1'b0, 3, 1'b0);
        chk("final_hit_cnt", {48'd0, hit_cnt}, 64'd1);
        chk("final_miss_cnt", {48'd0, miss_cnt}, 64'd1);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Lookup and refill controller for the instruction cache.
- Owns the tag, valid and LRU state for a 2-way set-associative cache. Sequences each fetch request: lookup, miss refill from instruction memory, and response.
- Drives the external instruction data array: write port during refill, read address on response.
- Sits between the fetch stage (inst_get/ptr/ready handshake) and instruction memory.

Parameters:
- WORD_SIZE, 32, instruction and address width (word addresses).
- BLOCK_SIZE, 16, words per line; offset = ptr[3:0].
- SET_SIZE, 1024, sets; index = ptr[13:4].
- CHANNEL_SIZE, 2, ways; fixed at 2.
- TAG_SIZE, 18, tag = ptr[31:14].
- CNT_W, 16, hit/miss counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_get  in  1  fetch request
- ptr  in  WORD_SIZE  fetch word address; requester holds it stable until ready
- flush  in  1  invalidate all lines
- ready  out  1  one-cycle response pulse
- hit  out  1  qualifies ready: 1 = hit, 0 = served after refill
- busy  out  1  high in any state other than IDLE
- mem_req  out  1  memory read request
- mem_addr  out  WORD_SIZE  memory read address
- mem_ack  in  1  mem_rdata valid for current mem_addr
- mem_rdata  in  WORD_SIZE  memory read data
- da_we  out  1  data array write enable
- da_way  out  1  data array way (write or read)
- da_set  out  10  data array set
- da_off  out  4  data array word offset
- da_wdata  out  WORD_SIZE  data array write data
- hit_cnt  out  CNT_W  hits since reset
- miss_cnt  out  CNT_W  misses since reset

Behaviour:
- States: IDLE, LOOKUP, REFILL, RESP.
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE.
  - All valid bits cleared; all LRU bits cleared.
  - ready, hit, mem_req, da_we cleared; hit_cnt and miss_cnt cleared.
  - rst has priority over everything. Reset mid-REFILL abandons the refill: no tag or valid update, mem_req low the following cycle.
- IDLE:
  - flush=1: clear all valid bits in one cycle, stay in IDLE. flush wins over a simultaneous inst_get.
  - Otherwise inst_get=1: latch ptr, go to LOOKUP.
  - flush outside IDLE is ignored. inst_get outside IDLE is ignored (not queued).
- LOOKUP: compare the latched tag against both ways of the set, qualified by valid.
  - Hit on way w: lru[set] <= ~w, hit_cnt++, go to RESP with hit=1.
  - Both ways hit is impossible by construction; if it occurs, way 0 is used.
  - Miss: select victim (first invalid way, way 0 first; otherwise the way given by lru[set]), miss_cnt++, word counter = 0, go to REFILL.
- REFILL:
  - mem_req=1 continuously.
  - mem_addr = {tag, set, counter}; block base first, offsets ascending.
  - Each cycle with mem_ack=1: da_we=1 combinationally, da_way=victim, da_set=set, da_off=counter, da_wdata=mem_rdata; counter increments.
  - Back-to-back acks allowed, one word per cycle.
  - On the ack with counter=15: write tag, set valid, lru[set] <= ~victim, drop mem_req, go to RESP with hit=0.
  - Minimum refill time is 16 cycles.
- RESP:
  - ready=1 for exactly one cycle.
  - da_way, da_set, da_off address the requested word; the data array read is combinational.
  - Returns to IDLE; a new inst_get is accepted in the next IDLE cycle.
- Latency:
  - Hit: inst_get sampled at edge k, ready high during the cycle after edge k+2.
  - Miss: 3 cycles plus the refill duration.
- Counters saturate at all-ones and do not wrap.
- busy=1 in LOOKUP, REFILL and RESP.
- da_we is 0 outside REFILL ack cycles.

Test Plan:
- Reset, then inst_get with ptr=0x0000_0040 -> miss. mem_addr steps 0x40..0x4F. With mem_ack tied high, 16 writes to way 0 set 4. ready with hit=0; miss_cnt=1.
- Repeat ptr=0x0000_0045 -> hit=1, ready on the 3rd cycle after inst_get, da_way=0, da_off=5; hit_cnt=1, no mem_req.
- Fill set 4 with tags A and B, touch A, then request tag C -> victim is way of B; re-requesting B misses, re-requesting A hits.
- mem_ack stalled randomly (e.g., acks only every 3rd cycle) -> mem_addr holds until ack, exactly 16 da_we pulses, data matches memory model.
- flush and inst_get asserted together in IDLE -> flush taken first. Held inst_get is then processed as a miss on a previously valid line.
- rst asserted on the 8th refill word -> mem_req low next cycle. Line stays invalid; the following request to the same address misses and refills all 16 words.
